// File: rtl/bp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : bp_pkg                                                |
// | Purpose  : Shared helpers for the branch predictor: index width, |
// |            index/tag extraction, saturating counter arithmetic   |
// |            and counter reset value.                              |
// | Revision : 1.0 - initial parametrised predictor                  |
// +------------------------------------------------------------------+
package bp_pkg;

  // Index width for a power-of-two table depth.
  function automatic int bp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Table index: word-aligned PC bits just above the byte offset.
  function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Tag: the TAG_BITS bits directly above the index; zero when untagged.
  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w,
                                         input int tag_bits);
    logic [31:0] mask;
    if (tag_bits == 0) begin
      return 32'd0;
    end
    mask = (tag_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << tag_bits) - 32'd1);
    return (pc >> (idx_w + 2)) & mask;
  endfunction

  // Saturating up/down counter step for widths up to 4 bits.
  function automatic logic [3:0] bp_sat_upd(input logic [3:0] c, input logic up,
                                            input int bits);
    logic [3:0] cmax;
    cmax = 4'((5'd1 << bits) - 5'd1);
    if (up) begin
      return (c == cmax) ? c : c + 4'd1;
    end
    return (c == 4'd0) ? c : c - 4'd1;
  endfunction

  // Weakly not-taken reset value: 2^(bits-1)-1, which is 0 for a 1-bit counter.
  function automatic logic [3:0] bp_ctr_rst(input int bits);
    if (bits <= 1) begin
      return 4'd0;
    end
    return 4'((5'd1 << (bits - 1)) - 5'd1);
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bp_btb                                                |
// | Purpose  : Direct-mapped tagged branch target buffer. Combinational|
// |            read port, synchronous write port, valid bits cleared |
// |            asynchronously by the active-low reset.               |
// | Revision : 1.0 - initial parametrised predictor                  |
// +------------------------------------------------------------------+
module bp_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_rd_hit,
  output logic [31:0]      o_rd_target,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [31:0]      i_wr_target
);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  // Valid bits: only these need a reset, a cleared valid masks stale tag/target.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and target payload, written on every allocation or replacement.
  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

  // Read port returns pre-write contents on a same-cycle collision.
  always_comb begin
    o_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    o_rd_target = r_target[i_rd_idx];
  end

endmodule : bp_btb
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : branch_predictor                                      |
// | Purpose  : Bimodal (or gshare) saturating-counter predictor plus |
// |            tagged BTB. Zero-latency lookup from IF, one update   |
// |            per cycle from ID.                                    |
// | Options  : BP_GSHARE_EN - XOR global history into counter index  |
// | Revision : 1.0 - initial parametrised predictor                  |
// +------------------------------------------------------------------+
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int c_IDX_W = bp_idx_w(ENTRIES);
  // Untagged builds still keep a 1-bit tag that is always written/compared as 0.
  localparam int c_TAG_W = (TAG_BITS == 0) ? 1 : TAG_BITS;
  localparam logic [CTR_BITS-1:0] c_CTR_RST = CTR_BITS'(bp_ctr_rst(CTR_BITS));

  logic [c_IDX_W-1:0]  w_pidx;
  logic [c_IDX_W-1:0]  w_uidx;
  logic [c_TAG_W-1:0]  w_ptag;
  logic [c_TAG_W-1:0]  w_utag;
  logic [c_IDX_W-1:0]  w_cidx_rd;
  logic [c_IDX_W-1:0]  w_cidx_wr;
  logic [CTR_BITS-1:0] w_ctr_rd;
  logic                w_btb_hit;
  logic [31:0]         w_btb_target;
  logic [CTR_BITS-1:0] r_ctr [ENTRIES];

  assign w_pidx = c_IDX_W'(bp_idx(pred_pc, c_IDX_W));
  assign w_uidx = c_IDX_W'(bp_idx(upd_pc, c_IDX_W));
  assign w_ptag = c_TAG_W'(bp_tag(pred_pc, c_IDX_W, TAG_BITS));
  assign w_utag = c_TAG_W'(bp_tag(upd_pc, c_IDX_W, TAG_BITS));

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;

  // Lookup and update both hash with the current history; the update's own
  // outcome only shifts in at the edge, so it sees the pre-shift value.
  assign w_cidx_rd = w_pidx ^ c_IDX_W'(r_ghr);
  assign w_cidx_wr = w_uidx ^ c_IDX_W'(r_ghr);

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      // Single-bit history simply remembers the last resolved outcome.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_ghr <= '0;
        end else if (upd_valid) begin
          r_ghr <= upd_taken;
        end
      end
    end else begin : g_ghr_shift
      // Shift the resolved outcome into the history register.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_ghr <= '0;
        end else if (upd_valid) begin
          r_ghr <= {r_ghr[GHR_BITS-2:0], upd_taken};
        end
      end
    end
  endgenerate
`else
  // History length has no meaning for a bimodal predictor.
  localparam int c_unused_ghr_bits = GHR_BITS;

  assign w_cidx_rd = w_pidx;
  assign w_cidx_wr = w_uidx;
`endif

  // Saturating counter training; counters are untagged so aliases share one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= c_CTR_RST;
      end
    end else if (upd_valid) begin
      r_ctr[w_cidx_wr] <= CTR_BITS'(bp_sat_upd(4'(r_ctr[w_cidx_wr]), upd_taken, CTR_BITS));
    end
  end

  // BTB only learns taken branches; a not-taken miss never allocates.
  bp_btb #(
    .ENTRIES (ENTRIES),
    .IDX_W   (c_IDX_W),
    .TAG_W   (c_TAG_W)
  ) u_btb (
    .CLK         (CLK),
    .RST         (RST),
    .i_rd_idx    (w_pidx),
    .i_rd_tag    (w_ptag),
    .o_rd_hit    (w_btb_hit),
    .o_rd_target (w_btb_target),
    .i_wr_en     (upd_valid && upd_taken),
    .i_wr_idx    (w_uidx),
    .i_wr_tag    (w_utag),
    .i_wr_target (upd_target)
  );

  // Same-cycle prediction; a BTB miss falls through to the sequential PC.
  always_comb begin
    w_ctr_rd    = r_ctr[w_cidx_rd];
    pred_hit    = w_btb_hit;
    pred_taken  = w_btb_hit && w_ctr_rd[CTR_BITS-1];
    pred_target = w_btb_hit ? w_btb_target : pred_pc + 32'd4;
  end

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_branch_predictor                                   |
// | Purpose  : Directed self-checking bench for branch_predictor     |
// |            (ENTRIES=16, CTR_BITS=2, TAG_BITS=8). With            |
// |            BP_GSHARE_EN defined it runs the history-hash case    |
// |            with GHR_BITS=2.                                      |
// | Revision : 1.0 - initial bench                                   |
// +------------------------------------------------------------------+
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES  (16),
    .CTR_BITS (2),
    .TAG_BITS (8),
    .GHR_BITS (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pred_pc     (pred_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare all three prediction outputs against hand-computed values.
  task automatic chk(input string tag, input logic h, input logic t, input logic [31:0] tgt);
    checks++;
    assert ({pred_hit, pred_taken, pred_target} === {h, t, tgt})
    else begin
      errors++;
      $error("FAIL %s: observed hit=%b taken=%b target=%h expected hit=%b taken=%b target=%h",
             tag, pred_hit, pred_taken, pred_target, h, t, tgt);
    end
  endtask

  // Set pred_pc away from the clock edge, let the lookup settle, then check.
  task automatic look(input string tag, input logic [31:0] pc, input logic h,
                      input logic t, input logic [31:0] tgt);
    pred_pc = pc;
    #1;
    chk(tag, h, t, tgt);
  endtask

  // One resolved-branch update committed on the next rising edge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    @(posedge CLK);
    #1;
    upd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST        = 1'b0;
    pred_pc    = 32'h40;
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    do_reset();

`ifdef BP_GSHARE_EN
    // History hash: two taken updates train ctr[0] then ctr[1]; GHR ends at 11.
    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    look("gs_lookup_ctr3", 32'h40, 1'b1, 1'b0, 32'h100);
    // Update at 0x4C uses GHR=11 -> ctr[3^3=0] goes 10->11; GHR stays 11.
    upd(32'h4C, 1'b1, 32'h500);
    look("gs_lookup_ctr0", 32'h4C, 1'b1, 1'b1, 32'h500);
    look("gs_lookup_ctr3b", 32'h40, 1'b1, 1'b0, 32'h100);
    // Not-taken miss at 0x48 trains ctr[2^3=1] but never allocates the BTB.
    upd(32'h48, 1'b0, 32'h0);
    look("gs_no_alloc", 32'h48, 1'b0, 1'b0, 32'h4C);
    // GHR now 10: lookup 0x40 reads ctr[0^2=2], still at reset value.
    look("gs_ghr_shift", 32'h40, 1'b1, 1'b0, 32'h100);
    RST = 1'b0;
    #1;
    look("gs_async_rst", 32'h40, 1'b0, 1'b0, 32'h44);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    look("gs_after_rst", 32'h4C, 1'b0, 1'b0, 32'h50);
`else
    // Reset state with assorted lookup PCs, including the +4 wrap.
    look("rst_0x40", 32'h40, 1'b0, 1'b0, 32'h44);
    look("rst_0x0", 32'h0, 1'b0, 1'b0, 32'h4);
    look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // First taken update: ctr 01->10, BTB allocates.
    upd(32'h40, 1'b1, 32'h100);
    look("alloc_taken", 32'h40, 1'b1, 1'b1, 32'h100);

    // Train down: 10->01->00, BTB retains target.
    upd(32'h40, 1'b0, 32'h0);
    look("dec_to_01", 32'h40, 1'b1, 1'b0, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    look("dec_to_00", 32'h40, 1'b1, 1'b0, 32'h100);
    // Saturate low: 00 stays 00, so a single taken step only reaches 01.
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h100);
    look("sat_low", 32'h40, 1'b1, 1'b0, 32'h100);
    // Four more taken: 10,11,11,11.
    repeat (4) upd(32'h40, 1'b1, 32'h100);
    look("sat_high", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    look("dec_from_11", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    look("dec_to_01b", 32'h40, 1'b1, 1'b0, 32'h100);

    // Aliasing PC 0x80: same idx 0, tag 2 vs 1.
    look("alias_miss", 32'h80, 1'b0, 1'b0, 32'h84);
    upd(32'h80, 1'b1, 32'h200);
    look("alias_replace", 32'h80, 1'b1, 1'b1, 32'h200);
    look("alias_evicted", 32'h40, 1'b0, 1'b0, 32'h44);

    // Not-taken miss does not allocate.
    upd(32'h44, 1'b0, 32'h0);
    look("no_alloc_nt", 32'h44, 1'b0, 1'b0, 32'h48);

    // Reinstall 0x40 (shared ctr 10->11), then read/write collision.
    upd(32'h40, 1'b1, 32'h100);
    pred_pc    = 32'h40;
    upd_valid  = 1'b1;
    upd_pc     = 32'h40;
    upd_taken  = 1'b1;
    upd_target = 32'h300;
    #1;
    chk("collide_old", 1'b1, 1'b1, 32'h100);
    @(posedge CLK);
    #1;
    upd_valid = 1'b0;
    look("collide_new", 32'h40, 1'b1, 1'b1, 32'h300);

    // Asynchronous reset mid-cycle clears state without waiting for an edge.
    #2;
    RST = 1'b0;
    #1;
    look("async_rst", 32'h40, 1'b0, 1'b0, 32'h44);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    look("post_rst", 32'h40, 1'b0, 1'b0, 32'h44);
    // Counter back at 01: taken -> 10, then not-taken -> 01 (was 11 before reset).
    upd(32'h40, 1'b1, 32'h400);
    look("post_rst_tk", 32'h40, 1'b1, 1'b1, 32'h400);
    upd(32'h40, 1'b0, 32'h0);
    look("post_rst_ctr", 32'h40, 1'b1, 1'b0, 32'h400);

    // X on the lookup PC must leave state untouched.
    pred_pc = 32'hXXXX_XXXX;
    @(posedge CLK);
    #1;
    look("x_pc_safe", 32'h40, 1'b1, 1'b0, 32'h400);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
